// File: rtl/gpio_cmd_ctrl.sv
// PS<->PL GPIO mailbox command sequencer: captures a toggled request, runs it on the
// engine valid/ready port with a timeout, then publishes status and toggles ack.
module gpio_cmd_ctrl #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PS_2_PL_0_tri_o,
  input  logic [31:0] PS_2_PL_1_tri_o,
  output logic [31:0] PL_2_PS_0_tri_i,
  output logic [31:0] PL_2_PS_1_tri_i,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_write,
  output logic [15:0] cmd_addr,
  output logic [31:0] cmd_wdata,
  input  logic        rsp_valid,
  input  logic        rsp_err,
  input  logic [31:0] rsp_rdata,
  output logic [1:0]  led
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DONE} state_t;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ENG = 2'b01;
  localparam logic [1:0] ST_TO  = 2'b10;
  localparam logic [1:0] ST_ILL = 2'b11;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_WR  = 4'd1;
  localparam logic [3:0] OP_RD  = 4'd2;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic                   ack_q;
  logic                   busy_q;
  logic                   err_q;
  logic                   pending;

  logic [3:0]  op_q;
  logic [15:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  in_op;

  logic [TO_W-1:0] to_cnt_q;
  logic            to_last;

  logic        latch_cmd;
  logic        res_we;
  logic [1:0]  res_status_d, res_status_q;
  logic [31:0] res_rdata_d, res_rdata_q;

  logic [1:0]  out_status_q;
  logic [3:0]  out_op_q;
  logic [15:0] out_addr_q;
  logic [31:0] out_rdata_q;

  logic unused_bits;
  assign unused_bits = ^{PS_2_PL_0_tri_o[30:28], PS_2_PL_0_tri_o[23:16]};

  assign in_op   = PS_2_PL_0_tri_o[27:24];
  assign req_s   = sync_q[SYNC_STAGES-1];
  assign pending = (req_s != ack_q);
  assign to_last = (to_cnt_q == TO_LAST);

  // Only the request bit crosses domains; the other mailbox fields are held stable by the PS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], PS_2_PL_0_tri_o[31]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    latch_cmd    = 1'b0;
    res_we       = 1'b0;
    res_status_d = ST_OK;
    res_rdata_d  = '0;
    case (state_q)
      IDLE: begin
        if (pending) begin
          latch_cmd = 1'b1;
          if (in_op == OP_WR || in_op == OP_RD) begin
            state_d = ISSUE;
          end else begin
            state_d      = DONE;
            res_we       = 1'b1;
            res_status_d = (in_op == OP_NOP) ? ST_OK : ST_ILL;
          end
        end
      end
      ISSUE: begin
        if (to_last) begin
          state_d      = DONE;
          res_we       = 1'b1;
          res_status_d = ST_TO;
        end else if (cmd_ready) begin
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        // A response on the terminal count still wins over the timeout.
        if (rsp_valid) begin
          state_d      = DONE;
          res_we       = 1'b1;
          res_status_d = rsp_err ? ST_ENG : ST_OK;
          res_rdata_d  = (op_q == OP_RD) ? rsp_rdata : 32'h0;
        end else if (to_last) begin
          state_d      = DONE;
          res_we       = 1'b1;
          res_status_d = ST_TO;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      res_status_q <= ST_OK;
      res_rdata_q <= '0;
      to_cnt_q    <= '0;
    end else begin
      if (latch_cmd) begin
        op_q    <= in_op;
        addr_q  <= PS_2_PL_0_tri_o[15:0];
        wdata_q <= PS_2_PL_1_tri_o;
      end
      if (res_we) begin
        res_status_q <= res_status_d;
        res_rdata_q  <= res_rdata_d;
      end
      if (state_q == IDLE) begin
        to_cnt_q <= '0;
      end else if (state_q == ISSUE || state_q == WAIT_RSP) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
    end
  end

  // All PS-visible results change together on the edge that leaves DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q        <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      out_status_q <= ST_OK;
      out_op_q     <= '0;
      out_addr_q   <= '0;
      out_rdata_q  <= '0;
    end else if (state_q == DONE) begin
      ack_q        <= ~ack_q;
      busy_q       <= 1'b0;
      err_q        <= (res_status_q != ST_OK);
      out_status_q <= res_status_q;
      out_op_q     <= op_q;
      out_addr_q   <= addr_q;
      out_rdata_q  <= res_rdata_q;
    end else if (latch_cmd) begin
      busy_q <= 1'b1;
    end
  end

  assign cmd_valid = (state_q == ISSUE);
  assign cmd_write = (op_q == OP_WR);
  assign cmd_addr  = addr_q;
  assign cmd_wdata = wdata_q;

  assign PL_2_PS_0_tri_i = {ack_q, busy_q, out_status_q, out_op_q, 8'h00, out_addr_q};
  assign PL_2_PS_1_tri_i = out_rdata_q;
  assign led             = {err_q, busy_q};

endmodule

// File: tb/tb_gpio_cmd_ctrl.sv
// Directed bench for gpio_cmd_ctrl: NOP, write, read error, timeout, illegal, race and reset.
module tb_gpio_cmd_ctrl;

  localparam int SYNC_STAGES    = 2;
  localparam int TIMEOUT_CYCLES = 8;
  localparam int TO_W           = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ps0, ps1;
  logic [31:0] pl0, pl1;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  led;

  int checks = 0;
  int fails  = 0;
  int hsCount = 0;
  int validCycles = 0;
  logic        lastWrite = 1'b0;
  logic [15:0] lastAddr  = '0;
  logic [31:0] lastWdata = '0;
  logic        reqBit = 1'b0;
  int cyc;
  int hsBefore;
  int validBefore;

  always #5 clk = ~clk;

  gpio_cmd_ctrl #(
    .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W(TO_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .PS_2_PL_0_tri_o(ps0),
    .PS_2_PL_1_tri_o(ps1),
    .PL_2_PS_0_tri_i(pl0),
    .PL_2_PS_1_tri_i(pl1),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata),
    .led(led)
  );

  // Engine-side monitor: records every accepted command.
  always @(posedge clk) begin
    if (cmd_valid) validCycles++;
    if (cmd_valid && cmd_ready) begin
      hsCount++;
      lastWrite = cmd_write;
      lastAddr  = cmd_addr;
      lastWdata = cmd_wdata;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed %08h expected %08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [15:0] addr, input logic [31:0] wdata);
    reqBit = ~reqBit;
    ps0 = {reqBit, 3'b000, op, 8'h00, addr};
    ps1 = wdata;
  endtask

  task automatic waitAck(input string tag, input logic expAck, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (pl0[31] !== expAck && cycles < 64);
    if (pl0[31] !== expAck) checkOutput(tag, 32'(pl0[31]), 32'(expAck));
  endtask

  task automatic waitCmdValid(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cmd_valid !== 1'b1 && n < 64);
    if (cmd_valid !== 1'b1) checkOutput(tag, 32'(cmd_valid), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    ps0 = '0; ps1 = '0;
    cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0; rsp_rdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_pl0", pl0, 32'h0);
    checkOutput("rst_pl1", pl1, 32'h0);
    checkOutput("rst_cmd_valid", 32'(cmd_valid), 32'h0);
    checkOutput("rst_led", 32'(led), 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("idle_pl0", pl0, 32'h0);

    // NOP: ack after SYNC_STAGES+2 cycles, busy visible in between
    validBefore = validCycles;
    applyStimulus(4'd0, 16'h1234, 32'h0);
    repeat (3) @(negedge clk);
    checkOutput("nop_busy", 32'(pl0[30]), 32'd1);
    checkOutput("nop_led_busy", 32'(led), 32'h1);
    waitAck("nop_ack", 1'b1, cyc);
    checkOutput("nop_latency", 32'(cyc + 3), 32'(SYNC_STAGES + 2));
    checkOutput("nop_pl0", pl0, 32'h8000_1234);
    checkOutput("nop_pl1", pl1, 32'h0);
    checkOutput("nop_no_valid", 32'(validCycles - validBefore), 32'd0);
    checkOutput("nop_led", 32'(led), 32'h0);

    // WRITE with cmd_ready held low for 5 cycles
    hsBefore = hsCount;
    applyStimulus(4'd1, 16'h0040, 32'hDEAD_BEEF);
    waitCmdValid("wr_valid_wait");
    checkOutput("wr_cmd_write", 32'(cmd_write), 32'd1);
    checkOutput("wr_cmd_addr", 32'(cmd_addr), 32'h0040);
    checkOutput("wr_cmd_wdata", cmd_wdata, 32'hDEAD_BEEF);
    repeat (5) @(negedge clk);
    checkOutput("wr_valid_held", 32'(cmd_valid), 32'd1);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    checkOutput("wr_valid_dropped", 32'(cmd_valid), 32'd0);
    rsp_valid = 1'b1; rsp_err = 1'b0; rsp_rdata = 32'h1111_2222;
    @(negedge clk);
    rsp_valid = 1'b0;
    waitAck("wr_ack", 1'b0, cyc);
    checkOutput("wr_handshakes", 32'(hsCount - hsBefore), 32'd1);
    checkOutput("wr_hs_write", 32'(lastWrite), 32'd1);
    checkOutput("wr_hs_addr", 32'(lastAddr), 32'h0040);
    checkOutput("wr_hs_wdata", lastWdata, 32'hDEAD_BEEF);
    checkOutput("wr_pl0", pl0, 32'h0100_0040);
    checkOutput("wr_pl1", pl1, 32'h0);
    checkOutput("wr_led", 32'(led), 32'h0);

    // READ with engine error
    cmd_ready = 1'b1;
    applyStimulus(4'd2, 16'h0010, 32'h0);
    waitCmdValid("rderr_valid_wait");
    @(negedge clk);
    rsp_valid = 1'b1; rsp_err = 1'b1; rsp_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    rsp_valid = 1'b0; rsp_err = 1'b0;
    waitAck("rderr_ack", 1'b1, cyc);
    checkOutput("rderr_hs_write", 32'(lastWrite), 32'd0);
    checkOutput("rderr_pl0", pl0, 32'h9200_0010);
    checkOutput("rderr_pl1", pl1, 32'hCAFE_F00D);
    checkOutput("rderr_led", 32'(led), 32'h2);

    // OK NOP clears sticky error
    applyStimulus(4'd0, 16'hABCD, 32'h0);
    waitAck("nop2_ack", 1'b0, cyc);
    checkOutput("nop2_pl0", pl0, 32'h0000_ABCD);
    checkOutput("nop2_led", 32'(led), 32'h0);

    // Timeout: READ accepted, no response for TIMEOUT_CYCLES
    applyStimulus(4'd2, 16'h0077, 32'h0);
    waitCmdValid("to_valid_wait");
    waitAck("to_ack", 1'b1, cyc);
    checkOutput("to_latency", 32'(cyc), 32'(TIMEOUT_CYCLES + 1));
    checkOutput("to_pl0", pl0, 32'hA200_0077);
    checkOutput("to_pl1", pl1, 32'h0);
    checkOutput("to_led", 32'(led), 32'h2);
    rsp_valid = 1'b1; rsp_err = 1'b1; rsp_rdata = 32'h5555_5555;
    @(negedge clk);
    rsp_valid = 1'b0; rsp_err = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("late_rsp_pl0", pl0, 32'hA200_0077);
    checkOutput("late_rsp_pl1", pl1, 32'h0);
    checkOutput("late_rsp_led", 32'(led), 32'h2);

    applyStimulus(4'd0, 16'h0001, 32'h0);
    waitAck("nop3_ack", 1'b0, cyc);
    checkOutput("nop3_pl0", pl0, 32'h0000_0001);
    checkOutput("nop3_led", 32'(led), 32'h0);

    // Illegal opcode never reaches the engine
    validBefore = validCycles;
    applyStimulus(4'd7, 16'h0BAD, 32'h0);
    waitAck("ill_ack", 1'b1, cyc);
    checkOutput("ill_pl0", pl0, 32'hB700_0BAD);
    checkOutput("ill_no_valid", 32'(validCycles - validBefore), 32'd0);
    checkOutput("ill_led", 32'(led), 32'h2);

    // Response on the terminal timeout count wins
    applyStimulus(4'd2, 16'h0022, 32'h0);
    waitCmdValid("race_valid_wait");
    repeat (TIMEOUT_CYCLES - 1) @(negedge clk);
    rsp_valid = 1'b1; rsp_err = 1'b0; rsp_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    rsp_valid = 1'b0;
    waitAck("race_ack", 1'b0, cyc);
    checkOutput("race_pl0", pl0, 32'h0200_0022);
    checkOutput("race_pl1", pl1, 32'h0BAD_F00D);
    checkOutput("race_led", 32'(led), 32'h0);

    // Reset in WAIT_RSP, request still pending at release
    applyStimulus(4'd2, 16'h0033, 32'h0);
    waitCmdValid("rstmid_valid_wait");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstmid_pl0", pl0, 32'h0);
    checkOutput("rstmid_pl1", pl1, 32'h0);
    checkOutput("rstmid_cmd_valid", 32'(cmd_valid), 32'h0);
    checkOutput("rstmid_cmd_addr", 32'(cmd_addr), 32'h0);
    checkOutput("rstmid_led", 32'(led), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    waitCmdValid("rstnew_valid_wait");
    checkOutput("rstnew_cmd_addr", 32'(cmd_addr), 32'h0033);
    @(negedge clk);
    rsp_valid = 1'b1; rsp_err = 1'b0; rsp_rdata = 32'h1234_5678;
    @(negedge clk);
    rsp_valid = 1'b0;
    waitAck("rstnew_ack", 1'b1, cyc);
    checkOutput("rstnew_pl0", pl0, 32'h8200_0033);
    checkOutput("rstnew_pl1", pl1, 32'h1234_5678);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
